// File: rtl/generador_vecinos_simd.sv
// generador_vecinos_simd: raster-walks the destination image, fetches the four
// source neighbours of every pixel and hands LANES-wide batches to the SIMD
// bilinear unit through its simd_iniciar / simd_listo handshake.
module generador_vecinos_simd #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iniciar_img,
  input  logic [8:0]              ancho_src,
  input  logic [8:0]              alto_src,
  input  logic [15:0]             ancho_dst,
  input  logic [15:0]             alto_dst,
  input  logic [15:0]             paso_x,
  input  logic [15:0]             paso_y,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_dir,
  input  logic [7:0]              mem_dato,
  output logic                    simd_iniciar,
  input  logic                    simd_listo,
  output logic [LANES-1:0][7:0]   p00_salida,
  output logic [LANES-1:0][7:0]   p10_salida,
  output logic [LANES-1:0][7:0]   p01_salida,
  output logic [LANES-1:0][7:0]   p11_salida,
  output logic [LANES-1:0][15:0]  fx_salida,
  output logic [LANES-1:0][15:0]  fy_salida,
  output logic [LANES-1:0]        carril_valido,
  output logic [15:0]             lote_x0,
  output logic [15:0]             lote_y,
  output logic                    ocupado,
  output logic                    fin_img
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {REPOSO, CARRIL, LEER, EMITIR, ESPERAR, FIN} estado_t;

  estado_t                 estado_q;
  logic [1:0]              fase_q;
  logic [LW-1:0]           carril_q;
  logic [8:0]              ancho_src_q, alto_src_q;
  logic [15:0]             ancho_dst_q, alto_dst_q, paso_x_q, paso_y_q;
  logic [15:0]             sx_q, sy_q, dst_x_q, dst_y_q;
  logic                    fin_pend_q;
  logic                    mem_rd_q, simd_iniciar_q, ocupado_q, fin_img_q;
  logic [ADDR_W-1:0]       mem_dir_q;
  logic [LANES-1:0][7:0]   p00_q, p10_q, p01_q, p11_q;
  logic [LANES-1:0][15:0]  fx_q, fy_q;
  logic [LANES-1:0]        valido_q;
  logic [15:0]             lote_x0_q, lote_y_q;

  // Neighbour+1 clamped to the last source column/row (size-1).
  function automatic logic [7:0] lim(input logic [7:0] c, input logic [8:0] n);
    logic [8:0] s;
    s = {1'b0, c} + 9'd1;
    return (s > (n - 9'd1)) ? 8'(n - 9'd1) : s[7:0];
  endfunction

  // Row-major source address, wrapping at the address width.
  function automatic logic [ADDR_W-1:0] dir_f(input logic [7:0] x, input logic [7:0] y,
                                               input logic [8:0] w);
    return ADDR_W'(y) * ADDR_W'(w) + ADDR_W'(x);
  endfunction

  logic [7:0]  x0, x1, y0, y1;
  logic        fin_fila, lote_lleno;
  logic [15:0] sx_d, sy_d;

  assign x0         = sx_q[15:8];
  assign y0         = sy_q[15:8];
  assign x1         = lim(x0, ancho_src_q);
  assign y1         = lim(y0, alto_src_q);
  assign fin_fila   = (dst_x_q == ancho_dst_q - 16'd1);
  assign lote_lleno = (carril_q == LW'(LANES - 1));
  assign sx_d       = fin_fila ? 16'd0 : sx_q + paso_x_q;
  assign sy_d       = fin_fila ? sy_q + paso_y_q : sy_q;

  // Batch/read sequencer: one lane = CARRIL (p00 read) + 4 LEER cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q       <= REPOSO;
      fase_q         <= '0;
      carril_q       <= '0;
      ancho_src_q    <= '0;
      alto_src_q     <= '0;
      ancho_dst_q    <= '0;
      alto_dst_q     <= '0;
      paso_x_q       <= '0;
      paso_y_q       <= '0;
      sx_q           <= '0;
      sy_q           <= '0;
      dst_x_q        <= '0;
      dst_y_q        <= '0;
      fin_pend_q     <= 1'b0;
      mem_rd_q       <= 1'b0;
      mem_dir_q      <= '0;
      simd_iniciar_q <= 1'b0;
      ocupado_q      <= 1'b0;
      fin_img_q      <= 1'b0;
      p00_q          <= '0;
      p10_q          <= '0;
      p01_q          <= '0;
      p11_q          <= '0;
      fx_q           <= '0;
      fy_q           <= '0;
      valido_q       <= '0;
      lote_x0_q      <= '0;
      lote_y_q       <= '0;
    end else begin
      case (estado_q)
        REPOSO: begin
          if (iniciar_img) begin
            ancho_src_q <= ancho_src;
            alto_src_q  <= alto_src;
            ancho_dst_q <= ancho_dst;
            alto_dst_q  <= alto_dst;
            paso_x_q    <= paso_x;
            paso_y_q    <= paso_y;
            sx_q        <= '0;
            sy_q        <= '0;
            dst_x_q     <= '0;
            dst_y_q     <= '0;
            carril_q    <= '0;
            fase_q      <= '0;
            fin_pend_q  <= 1'b0;
            if (ancho_dst == 16'd0 || alto_dst == 16'd0) begin
              fin_img_q <= 1'b1;
              estado_q  <= FIN;
            end else begin
              ocupado_q <= 1'b1;
              mem_rd_q  <= 1'b1;
              mem_dir_q <= '0;
              estado_q  <= CARRIL;
            end
          end
        end
        CARRIL: begin
          // Lane 0 opens a fresh batch: unused lanes must read back as zero.
          if (carril_q == '0) begin
            p00_q     <= '0;
            p10_q     <= '0;
            p01_q     <= '0;
            p11_q     <= '0;
            fx_q      <= '0;
            fy_q      <= '0;
            valido_q  <= '0;
            lote_x0_q <= dst_x_q;
            lote_y_q  <= dst_y_q;
          end
          fx_q[carril_q]     <= {8'h00, sx_q[7:0]};
          fy_q[carril_q]     <= {8'h00, sy_q[7:0]};
          valido_q[carril_q] <= 1'b1;
          mem_dir_q          <= dir_f(x1, y0, ancho_src_q);
          fase_q             <= '0;
          estado_q           <= LEER;
        end
        LEER: begin
          fase_q <= fase_q + 2'd1;
          case (fase_q)
            2'd0: begin
              p00_q[carril_q] <= mem_dato;
              mem_dir_q       <= dir_f(x0, y1, ancho_src_q);
            end
            2'd1: begin
              p10_q[carril_q] <= mem_dato;
              mem_dir_q       <= dir_f(x1, y1, ancho_src_q);
            end
            2'd2: begin
              p01_q[carril_q] <= mem_dato;
              mem_rd_q        <= 1'b0;
            end
            default: begin
              p11_q[carril_q] <= mem_dato;
              fin_pend_q      <= fin_fila && (dst_y_q == alto_dst_q - 16'd1);
              sx_q            <= sx_d;
              sy_q            <= sy_d;
              dst_x_q         <= fin_fila ? 16'd0 : dst_x_q + 16'd1;
              dst_y_q         <= fin_fila ? dst_y_q + 16'd1 : dst_y_q;
              if (fin_fila || lote_lleno) begin
                estado_q <= EMITIR;
              end else begin
                carril_q  <= carril_q + LW'(1);
                mem_rd_q  <= 1'b1;
                mem_dir_q <= dir_f(sx_d[15:8], sy_d[15:8], ancho_src_q);
                estado_q  <= CARRIL;
              end
            end
          endcase
        end
        EMITIR: begin
          simd_iniciar_q <= 1'b1;
          estado_q       <= ESPERAR;
        end
        ESPERAR: begin
          simd_iniciar_q <= 1'b0;
          if (simd_listo) begin
            if (fin_pend_q) begin
              fin_img_q <= 1'b1;
              ocupado_q <= 1'b0;
              estado_q  <= FIN;
            end else begin
              carril_q  <= '0;
              mem_rd_q  <= 1'b1;
              mem_dir_q <= dir_f(x0, y0, ancho_src_q);
              estado_q  <= CARRIL;
            end
          end
        end
        FIN: begin
          fin_img_q <= 1'b0;
          estado_q  <= REPOSO;
        end
        default: estado_q <= REPOSO;
      endcase
    end
  end

  assign mem_rd        = mem_rd_q;
  assign mem_dir       = mem_dir_q;
  assign simd_iniciar  = simd_iniciar_q;
  assign p00_salida    = p00_q;
  assign p10_salida    = p10_q;
  assign p01_salida    = p01_q;
  assign p11_salida    = p11_q;
  assign fx_salida     = fx_q;
  assign fy_salida     = fy_q;
  assign carril_valido = valido_q;
  assign lote_x0       = lote_x0_q;
  assign lote_y        = lote_y_q;
  assign ocupado       = ocupado_q;
  assign fin_img       = fin_img_q;

endmodule

// File: tb/tb_generador_vecinos_simd.sv
// Bench for generador_vecinos_simd: directed passes plus randomized sizes,
// checked against a per-pixel arithmetic model of the neighbour fetch.
module tb_generador_vecinos_simd;
  localparam int LANES  = 4;
  localparam int ADDR_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   iniciar_img;
  logic [8:0]             ancho_src, alto_src;
  logic [15:0]            ancho_dst, alto_dst, paso_x, paso_y;
  logic                   mem_rd;
  logic [ADDR_W-1:0]      mem_dir;
  logic [7:0]             mem_dato;
  logic                   simd_iniciar;
  logic                   simd_listo;
  logic [LANES-1:0][7:0]  p00_salida, p10_salida, p01_salida, p11_salida;
  logic [LANES-1:0][15:0] fx_salida, fy_salida;
  logic [LANES-1:0]       carril_valido;
  logic [15:0]            lote_x0, lote_y;
  logic                   ocupado, fin_img;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [0:65535];

  generador_vecinos_simd #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .iniciar_img(iniciar_img),
    .ancho_src(ancho_src), .alto_src(alto_src),
    .ancho_dst(ancho_dst), .alto_dst(alto_dst),
    .paso_x(paso_x), .paso_y(paso_y),
    .mem_rd(mem_rd), .mem_dir(mem_dir), .mem_dato(mem_dato),
    .simd_iniciar(simd_iniciar), .simd_listo(simd_listo),
    .p00_salida(p00_salida), .p10_salida(p10_salida),
    .p01_salida(p01_salida), .p11_salida(p11_salida),
    .fx_salida(fx_salida), .fy_salida(fy_salida),
    .carril_valido(carril_valido), .lote_x0(lote_x0), .lote_y(lote_y),
    .ocupado(ocupado), .fin_img(fin_img)
  );

  always #5 clk = ~clk;

  // Source memory: data valid the cycle after the strobe, zero otherwise.
  always @(posedge clk) mem_dato <= mem_rd ? mem[mem_dir] : 8'h00;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] lote_bits();
    return 512'({p00_salida, p10_salida, p01_salida, p11_salida,
                 fx_salida, fy_salida, carril_valido, lote_x0, lote_y});
  endfunction

  function automatic logic [511:0] all_bits();
    return 512'({lote_bits(), mem_rd, mem_dir, simd_iniciar, ocupado, fin_img});
  endfunction

  task automatic scramble();
    ancho_src = 9'($urandom);
    alto_src  = 9'($urandom);
    ancho_dst = 16'($urandom);
    alto_dst  = 16'($urandom);
    paso_x    = 16'($urandom);
    paso_y    = 16'($urandom);
  endtask

  function automatic int addr_of(input int x, input int y, input int w);
    return (y * w + x) % 65536;
  endfunction

  task automatic run_pass(input int aw, input int ah, input int dw, input int dh,
                          input int px, input int py, input int bp_min, input int bp_max);
    logic [LANES-1:0][7:0]  e00, e10, e01, e11;
    logic [LANES-1:0][15:0] efx, efy;
    logic [LANES-1:0]       ev;
    int                     ea[$];
    logic [ADDR_W-1:0]      ga[$];
    logic [511:0]           snap;
    int cyc, bp, n, sx, sy, x0, x1, y0, y1;
    snap = '0;
    ancho_src = 9'(aw); alto_src = 9'(ah);
    ancho_dst = 16'(dw); alto_dst = 16'(dh);
    paso_x = 16'(px); paso_y = 16'(py);
    iniciar_img = 1'b1;
    @(negedge clk);
    iniciar_img = 1'b0;
    scramble();
    if (dw == 0 || dh == 0) begin
      chk("zero_fin", 512'(fin_img), 512'(1));
      chk("zero_rd", 512'(mem_rd), 512'(0));
      chk("zero_simd", 512'(simd_iniciar), 512'(0));
      chk("zero_ocupado", 512'(ocupado), 512'(0));
      @(negedge clk);
      chk("zero_fin_pulse", 512'(fin_img), 512'(0));
      $display("pass %0dx%0d -> %0dx%0d: zero-size", aw, ah, dw, dh);
      return;
    end
    for (int y = 0; y < dh; y++) begin
      for (int bx = 0; bx < dw; bx += LANES) begin
        n = (dw - bx < LANES) ? dw - bx : LANES;
        ea.delete();
        for (int l = 0; l < LANES; l++) begin
          e00[l] = 8'h00; e10[l] = 8'h00; e01[l] = 8'h00; e11[l] = 8'h00;
          efx[l] = 16'h0; efy[l] = 16'h0; ev[l] = 1'b0;
          if (l < n) begin
            sx = ((bx + l) * px) % 65536;
            sy = (y * py) % 65536;
            x0 = sx / 256;
            y0 = sy / 256;
            x1 = (x0 + 1 < aw) ? x0 + 1 : aw - 1;
            y1 = (y0 + 1 < ah) ? y0 + 1 : ah - 1;
            ea.push_back(addr_of(x0, y0, aw));
            ea.push_back(addr_of(x1, y0, aw));
            ea.push_back(addr_of(x0, y1, aw));
            ea.push_back(addr_of(x1, y1, aw));
            e00[l] = mem[addr_of(x0, y0, aw)];
            e10[l] = mem[addr_of(x1, y0, aw)];
            e01[l] = mem[addr_of(x0, y1, aw)];
            e11[l] = mem[addr_of(x1, y1, aw)];
            efx[l] = 16'(sx % 256);
            efy[l] = 16'(sy % 256);
            ev[l]  = 1'b1;
          end
        end
        chk("first_rd", 512'(mem_rd), 512'(1));
        ga.delete();
        cyc = 0;
        while (!simd_iniciar && cyc < 400) begin
          if (mem_rd) ga.push_back(mem_dir);
          simd_listo  = 1'($urandom);
          iniciar_img = 1'($urandom);
          scramble();
          @(negedge clk);
          cyc++;
        end
        iniciar_img = 1'b0;
        simd_listo  = 1'b0;
        chk("latency", 512'(cyc), 512'(5 * n + 1));
        chk("n_reads", 512'(ga.size()), 512'(4 * n));
        for (int i = 0; i < ga.size() && i < ea.size(); i++)
          chk("rd_addr", 512'(ga[i]), 512'(ea[i]));
        chk("p00", 512'(p00_salida), 512'(e00));
        chk("p10", 512'(p10_salida), 512'(e10));
        chk("p01", 512'(p01_salida), 512'(e01));
        chk("p11", 512'(p11_salida), 512'(e11));
        chk("fx", 512'(fx_salida), 512'(efx));
        chk("fy", 512'(fy_salida), 512'(efy));
        chk("valid", 512'(carril_valido), 512'(ev));
        chk("lote_x0", 512'(lote_x0), 512'(bx));
        chk("lote_y", 512'(lote_y), 512'(y));
        chk("ocupado", 512'(ocupado), 512'(1));
        $display("batch (%0d,%0d) lanes=%0d mask=%b reads=%0d latency=%0d",
                 bx, y, n, carril_valido, ga.size(), cyc);
        snap = lote_bits();
        bp = $urandom_range(bp_min, bp_max);
        for (int k = 0; k < bp; k++) begin
          @(negedge clk);
          chk("bp_hold", lote_bits(), snap);
          chk("bp_rd", 512'(mem_rd), 512'(0));
          chk("bp_simd", 512'(simd_iniciar), 512'(0));
          chk("bp_fin", 512'(fin_img), 512'(0));
        end
        simd_listo = 1'b1;
        @(negedge clk);
        simd_listo = 1'b0;
      end
    end
    chk("fin", 512'(fin_img), 512'(1));
    chk("fin_ocupado", 512'(ocupado), 512'(0));
    chk("fin_rd", 512'(mem_rd), 512'(0));
    chk("fin_keep", lote_bits(), snap);
    @(negedge clk);
    chk("fin_pulse", 512'(fin_img), 512'(0));
    $display("pass %0dx%0d -> %0dx%0d done", aw, ah, dw, dh);
  endtask

  initial begin
    rst = 1'b1; iniciar_img = 1'b0; simd_listo = 1'b0;
    ancho_src = '0; alto_src = '0; ancho_dst = '0; alto_dst = '0;
    paso_x = '0; paso_y = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("reset_state", all_bits(), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_state", all_bits(), 512'(0));

    // Upscale 2x2 -> 4x1
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
    run_pass(2, 2, 4, 1, 16'h0080, 16'h0000, 0, 3);
    chk("up_p00", 512'(p00_salida), 512'(32'h14140A0A));
    chk("up_p10", 512'(p10_salida), 512'(32'h14141414));
    chk("up_p01", 512'(p01_salida), 512'(32'h28281E1E));
    chk("up_p11", 512'(p11_salida), 512'(32'h28282828));
    chk("up_fx", 512'(fx_salida), 512'(64'h0080_0000_0080_0000));
    chk("up_valid", 512'(carril_valido), 512'(4'b1111));

    // Partial batches across two rows
    run_pass(2, 2, 6, 2, 16'h0080, 16'h0080, 0, 2);
    chk("part_mask_last", 512'(carril_valido), 512'(4'b0011));

    // Backpressure: listo held low for 10 cycles
    run_pass(5, 3, 5, 2, 16'h00C0, 16'h0100, 10, 10);

    // Zero-size destinations
    run_pass(4, 4, 0, 3, 16'h0100, 16'h0100, 0, 0);
    run_pass(4, 4, 3, 0, 16'h0100, 16'h0100, 0, 0);

    // Edge clamp: 4x4 source, unit step, dst (3,3) lands in the corner
    run_pass(4, 4, 4, 4, 16'h0100, 16'h0100, 0, 2);
    chk("clamp_p00", 512'(p00_salida[3]), 512'(mem[15]));
    chk("clamp_p10", 512'(p10_salida[3]), 512'(mem[15]));
    chk("clamp_p01", 512'(p01_salida[3]), 512'(mem[15]));
    chk("clamp_p11", 512'(p11_salida[3]), 512'(mem[15]));
    chk("clamp_fxfy", 512'({fx_salida[3], fy_salida[3]}), 512'(0));

    // Asynchronous reset in the middle of LEER
    ancho_src = 9'd8; alto_src = 9'd8; ancho_dst = 16'd8; alto_dst = 16'd3;
    paso_x = 16'h0100; paso_y = 16'h0100;
    iniciar_img = 1'b1;
    @(negedge clk);
    iniciar_img = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async", all_bits(), 512'(0));
    $display("reset asserted mid-pass");
    @(negedge clk);
    rst = 1'b0;
    run_pass(8, 8, 8, 3, 16'h0100, 16'h0100, 0, 1);

    // Randomized sizes and steps
    for (int t = 0; t < 6; t++)
      run_pass($urandom_range(1, 256), $urandom_range(1, 256), $urandom_range(1, 9),
               $urandom_range(1, 3), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 65535)), 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/generador_vecinos_simd.md
Name: generador_vecinos_simd

Overview:
- Feeds the LANES-wide SIMD bilinear interpolation unit; sits on the producer side of its iniciar/listo batch interface.
- Walks the destination image in raster order and maps each destination pixel to a Q8.8 source coordinate.
- Reads the four source neighbours of each pixel from a byte-wide source memory, then assembles batches of LANES pixels with per-lane fx/fy.
- Hands each batch to the SIMD unit and waits for it to complete before building the next.

Parameters:
- LANES, 4, pixels per batch; must equal the SIMD unit's lane count.
- ADDR_W, 16, source memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- iniciar_img  in  1  one-cycle pulse; starts a full image pass.
- ancho_src, alto_src  in  9 each  source width/height, 1..256.
- ancho_dst, alto_dst  in  16 each  destination width/height.
- paso_x, paso_y  in  q8_8_t  source step per destination pixel/row.
- mem_rd  out  1  source memory read strobe.
- mem_dir  out  ADDR_W  source read address.
- mem_dato  in  8  read data, valid exactly 1 cycle after mem_rd.
- simd_iniciar  out  1  one-cycle pulse; batch outputs are valid.
- simd_listo  in  1  SIMD unit finished the batch.
- p00_salida, p10_salida, p01_salida, p11_salida  out  [7:0] x LANES  neighbour pixels.
- fx_salida, fy_salida  out  q8_8_t x LANES  fractions.
- carril_valido  out  LANES  per-lane valid mask.
- lote_x0, lote_y  out  16 each  destination coordinates of lane 0.
- ocupado  out  1  high from accepted iniciar_img until fin_img.
- fin_img  out  1  one-cycle pulse when the pass completes.

Behaviour:
- Reset (asynchronous, active-high; takes effect mid-operation too): every output = 0, FSM = REPOSO, all counters and accumulators cleared.
- Capture: all size/step inputs are captured on an accepted iniciar_img. iniciar_img is ignored while ocupado.
- FSM states: REPOSO -> CARRIL -> LEER -> EMITIR -> ESPERAR -> (CARRIL | FIN) -> REPOSO.
- Zero dimensions: if ancho_dst == 0 or alto_dst == 0, go REPOSO -> FIN. fin_img pulses the cycle after iniciar_img, with no mem_rd.
- Coordinates (all mod 2^16, no saturation):
  - sx = dst_x*paso_x and sy = dst_y*paso_y, computed by accumulation.
  - x0 = sx[15:8]; x1 = min(x0+1, ancho_src-1); y0/y1 likewise with alto_src-1.
  - fx = {8'h00, sx[7:0]}; fy = {8'h00, sy[7:0]}.
- Addresses: dir = y*ancho_src + x, truncated to ADDR_W.
- LEER, per lane:
  - mem_rd is high for 4 consecutive cycles, reading p00 (x0,y0), p10 (x1,y0), p01 (x0,y1), p11 (x1,y1) in that order.
  - Each byte is captured one cycle after its read, so one lane takes 5 cycles with no overlap between lanes.
- Batch fill: lanes fill from lane 0. A batch closes when LANES lanes are filled or the destination row ends; batches never span rows.
- Partial batches: unfilled lanes have carril_valido = 0 and all their data = 0.
- EMITIR: simd_iniciar = 1 for exactly one cycle. lote_x0/lote_y = destination coordinate of lane 0.
- ESPERAR:
  - All batch outputs are held stable and mem_rd = 0 until simd_listo.
  - simd_listo in any other state is ignored.
  - simd_listo in the same cycle as entering ESPERAR counts.
- After simd_listo: the next batch starts next cycle, or FIN if the last row and column were consumed.
- FIN: fin_img = 1 for one cycle, ocupado drops in the same cycle, then REPOSO. Batch outputs keep their last values.
- Latency, full batch: first mem_rd one cycle after iniciar_img; simd_iniciar 5*LANES+1 cycles after the first mem_rd.

Test Plan:
1. Upscale, first batch:
   - Stimulus: 2x2 source [10 20; 30 40], ancho_dst=4, alto_dst=1, paso_x=0x0080, paso_y=0, LANES=4.
   - Required: p00={10,10,20,20}, p10={20,20,20,20}, p01={30,30,40,40}, p11={40,40,40,40}.
   - Required: fx={0,0x80,0,0x80}, fy=0, carril_valido=4'b1111, exactly 16 mem_rd.
   - Required: simd_iniciar 21 cycles after the first mem_rd.
2. Partial batch:
   - Stimulus: ancho_dst=6, alto_dst=2.
   - Required: 4 batches with masks 1111, 0011, 1111, 0011.
   - Required: (lote_x0, lote_y) = (0,0), (4,0), (0,1), (4,1); fin_img only after the 4th simd_listo.
3. Backpressure:
   - Stimulus: hold simd_listo low 10 cycles after simd_iniciar.
   - Required: single simd_iniciar pulse, outputs bit-stable, mem_rd=0 throughout.
   - Required: next batch's mem_rd the cycle after simd_listo.
4. Zero size:
   - Stimulus: ancho_dst=0.
   - Required: fin_img pulses 1 cycle after iniciar_img, no mem_rd, no simd_iniciar.
   - Stimulus: iniciar_img pulsed while ocupado.
   - Required: ignored; the pass completes unchanged.
5. Edge clamp:
   - Stimulus: ancho_src=alto_src=4, paso_x=paso_y=0x0100, dst 4x4.
   - Required: at dst (3,3), reads of address 15 four times, fx=fy=0.
6. Reset mid-pass:
   - Stimulus: assert rst during LEER.
   - Required: outputs 0 asynchronously, ocupado=0.
   - Required: a following iniciar_img restarts at dst (0,0), with first read address 0.
